// File: rtl/id_issue_buffer_if.sv
// Decode-to-issue handshake bundle for the multi-lane issue buffer.
// master drives decode lanes and issue acks; slave is the buffer.
interface id_issue_buffer_if #(
    parameter int unsigned NrIn      = 2,
    parameter int unsigned NrOut     = 2,
    parameter int unsigned DataWidth = 64
);
    logic [NrIn-1:0]            dec_valid_i;
    logic [NrIn*DataWidth-1:0]  dec_data_i;
    logic [NrIn-1:0]            dec_ctrl_flow_i;
    logic [NrIn-1:0]            dec_ready_o;
    logic [NrOut-1:0]           issue_valid_o;
    logic [NrOut*DataWidth-1:0] issue_data_o;
    logic [NrOut-1:0]           issue_ctrl_flow_o;
    logic [NrOut-1:0]           issue_ack_i;

    modport master (
        output dec_valid_i, dec_data_i, dec_ctrl_flow_i, issue_ack_i,
        input  dec_ready_o, issue_valid_o, issue_data_o, issue_ctrl_flow_o
    );

    modport slave (
        input  dec_valid_i, dec_data_i, dec_ctrl_flow_i, issue_ack_i,
        output dec_ready_o, issue_valid_o, issue_data_o, issue_ctrl_flow_o
    );
endinterface

// File: rtl/id_issue_buffer.sv
// Circular FIFO between decode and issue: NrIn pushes and NrOut pops per cycle,
// with optional serialisation of control-flow entries onto issue slot 0.
module id_issue_buffer #(
    parameter int unsigned NrIn              = 2,
    parameter int unsigned NrOut             = 2,
    parameter int unsigned Depth             = 4,
    parameter int unsigned DataWidth         = 64,
    parameter bit          CtrlFlowSerialize = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    id_issue_buffer_if.slave bus
);
    localparam int unsigned CW = $clog2(Depth + 1);
    localparam int unsigned PW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned SW = CW + 1;

    logic [DataWidth-1:0] mem_data [Depth];
    logic [Depth-1:0]     mem_cf;
    logic [PW-1:0]        rd_ptr;
    logic [PW-1:0]        wr_ptr;
    logic [CW-1:0]        count;

    logic [NrOut-1:0]           raw;
    logic [NrOut-1:0]           vld;
    logic [NrOut-1:0]           cf_out;
    logic [NrOut*DataWidth-1:0] data_out;
    logic [NrIn-1:0]            rdy;
    logic [CW-1:0]              pops;
    logic [CW-1:0]              pushes;
    logic [SW-1:0]              free;
    logic [PW-1:0]              idx;
    logic                       blk;
    logic                       run;

    // base + off stays below 2*Depth, so one conditional subtract wraps it
    function automatic logic [PW-1:0] wrap(input logic [PW-1:0] base,
                                           input logic [SW-1:0] off);
        logic [SW-1:0] sum;
        sum = SW'(base) + off;
        if (sum >= SW'(Depth)) sum = sum - SW'(Depth);
        return PW'(sum);
    endfunction

    always_comb begin
        raw      = '0;
        vld      = '0;
        cf_out   = '0;
        data_out = '0;
        idx      = '0;
        blk      = 1'b0;
        run      = 1'b1;
        pops     = '0;
        for (int j = 0; j < NrOut; j++) begin
            idx    = wrap(rd_ptr, SW'(j));
            raw[j] = count > CW'(j);
            cf_out[j] = mem_cf[idx];
            data_out[j*DataWidth +: DataWidth] = mem_data[idx];
            if (CtrlFlowSerialize && j > 0 && (blk || (raw[j] && cf_out[j])))
                vld[j] = 1'b0;
            else
                vld[j] = raw[j];
            blk = blk || (raw[j] && cf_out[j]) || (raw[j] && !vld[j]);
            if (run && vld[j] && bus.issue_ack_i[j]) pops = pops + 1'b1;
            else run = 1'b0;
        end
    end

    always_comb begin
        rdy    = '0;
        pushes = '0;
        free   = SW'(Depth) - SW'(count) + SW'(pops);
        for (int k = 0; k < NrIn; k++) begin
            rdy[k] = free > SW'(k);
            if (bus.dec_valid_i[k] && rdy[k]) pushes = pushes + 1'b1;
        end
    end

    assign bus.issue_valid_o     = vld;
    assign bus.issue_data_o      = data_out;
    assign bus.issue_ctrl_flow_o = cf_out;
    assign bus.dec_ready_o       = rdy;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            mem_cf <= '0;
            for (int i = 0; i < Depth; i++) mem_data[i] <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            for (int k = 0; k < NrIn; k++) begin
                if (bus.dec_valid_i[k] && rdy[k]) begin
                    mem_data[wrap(wr_ptr, SW'(k))] <=
                        bus.dec_data_i[k*DataWidth +: DataWidth];
                    mem_cf[wrap(wr_ptr, SW'(k))] <= bus.dec_ctrl_flow_i[k];
                end
            end
            rd_ptr <= wrap(rd_ptr, SW'(pops));
            wr_ptr <= wrap(wr_ptr, SW'(pushes));
            count  <= count + pushes - pops;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (((bus.dec_valid_i + 1'b1) & bus.dec_valid_i) == '0)
                else $error("dec_valid_i is not a prefix");
            assert (count <= CW'(Depth)) else $error("count overflow");
            assert (pops <= count) else $error("pop beyond count");
            assert (wr_ptr == wrap(rd_ptr, SW'(count)))
                else $error("pointer/count mismatch");
        end
    end
endmodule

// File: tb/tb_id_issue_buffer.sv
// Directed bench for id_issue_buffer: Depth=4 for fill/flush/serialise,
// Depth=3 for a wrap-around stream against a queue model.
module tb_id_issue_buffer;
    logic clk = 1'b0;
    logic rst;
    logic flush_a;
    logic flush_b;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    id_issue_buffer_if #(.NrIn(2), .NrOut(2), .DataWidth(16)) bus_a ();
    id_issue_buffer_if #(.NrIn(2), .NrOut(2), .DataWidth(16)) bus_b ();

    id_issue_buffer #(
        .NrIn(2), .NrOut(2), .Depth(4), .DataWidth(16), .CtrlFlowSerialize(1'b1)
    ) u_a (
        .clk_i(clk), .rst_i(rst), .flush_i(flush_a), .bus(bus_a)
    );

    id_issue_buffer #(
        .NrIn(2), .NrOut(2), .Depth(3), .DataWidth(16), .CtrlFlowSerialize(1'b1)
    ) u_b (
        .clk_i(clk), .rst_i(rst), .flush_i(flush_b), .bus(bus_b)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic [1:0] v, input logic [15:0] d0,
                           input logic [15:0] d1, input logic [1:0] cf,
                           input logic [1:0] ack);
        bus_a.dec_valid_i     = v;
        bus_a.dec_data_i      = {d1, d0};
        bus_a.dec_ctrl_flow_i = cf;
        bus_a.issue_ack_i     = ack;
        #1;
    endtask

    logic [15:0] q[$];
    logic [15:0] seq;
    int          nv;
    int          pops;
    int          free;
    int          pushes;
    logic [1:0]  ack;

    initial begin
        rst     = 1'b1;
        flush_a = 1'b0;
        flush_b = 1'b0;
        bus_a.dec_valid_i = '0; bus_a.dec_data_i = '0;
        bus_a.dec_ctrl_flow_i = '0; bus_a.issue_ack_i = '0;
        bus_b.dec_valid_i = '0; bus_b.dec_data_i = '0;
        bus_b.dec_ctrl_flow_i = '0; bus_b.issue_ack_i = '0;
        tick();
        tick();
        rst = 1'b0;

        chk("rst_valid", 32'(bus_a.issue_valid_o), 32'h0);
        chk("rst_data", 32'(bus_a.issue_data_o), 32'h0);
        chk("rst_cf", 32'(bus_a.issue_ctrl_flow_o), 32'h0);
        chk("rst_ready", 32'(bus_a.dec_ready_o), 32'h3);

        drive_a(2'b11, 16'h00A0, 16'h00B0, 2'b00, 2'b00);
        tick();
        chk("fill1_valid", 32'(bus_a.issue_valid_o), 32'h3);
        chk("fill1_ready", 32'(bus_a.dec_ready_o), 32'h3);
        drive_a(2'b11, 16'h00C0, 16'h00D0, 2'b00, 2'b00);
        tick();
        drive_a(2'b00, 16'h0, 16'h0, 2'b00, 2'b00);
        chk("full_ready", 32'(bus_a.dec_ready_o), 32'h0);
        chk("full_valid", 32'(bus_a.issue_valid_o), 32'h3);
        chk("full_slot0", 32'(bus_a.issue_data_o[15:0]), 32'h00A0);
        chk("full_slot1", 32'(bus_a.issue_data_o[31:16]), 32'h00B0);

        drive_a(2'b11, 16'h00E0, 16'h00F0, 2'b00, 2'b11);
        chk("fullpop_ready", 32'(bus_a.dec_ready_o), 32'h3);
        tick();
        drive_a(2'b00, 16'h0, 16'h0, 2'b00, 2'b00);
        chk("fullpop_slot0", 32'(bus_a.issue_data_o[15:0]), 32'h00C0);
        chk("fullpop_slot1", 32'(bus_a.issue_data_o[31:16]), 32'h00D0);
        chk("fullpop_ready_after", 32'(bus_a.dec_ready_o), 32'h0);

        drive_a(2'b00, 16'h0, 16'h0, 2'b00, 2'b10);
        chk("gap_ready", 32'(bus_a.dec_ready_o), 32'h0);
        tick();
        drive_a(2'b00, 16'h0, 16'h0, 2'b00, 2'b00);
        chk("gap_slot0", 32'(bus_a.issue_data_o[15:0]), 32'h00C0);
        chk("gap_ready_after", 32'(bus_a.dec_ready_o), 32'h0);

        drive_a(2'b00, 16'h0, 16'h0, 2'b00, 2'b11);
        tick();
        chk("drain_slot0", 32'(bus_a.issue_data_o[15:0]), 32'h00E0);
        chk("drain_slot1", 32'(bus_a.issue_data_o[31:16]), 32'h00F0);
        drive_a(2'b00, 16'h0, 16'h0, 2'b00, 2'b11);
        tick();
        drive_a(2'b00, 16'h0, 16'h0, 2'b00, 2'b00);
        chk("empty_valid", 32'(bus_a.issue_valid_o), 32'h0);
        chk("empty_ready", 32'(bus_a.dec_ready_o), 32'h3);

        drive_a(2'b11, 16'h0B00, 16'h0AD0, 2'b01, 2'b00);
        tick();
        drive_a(2'b00, 16'h0, 16'h0, 2'b00, 2'b00);
        chk("br_add_valid", 32'(bus_a.issue_valid_o), 32'h1);
        chk("br_add_cf", 32'(bus_a.issue_ctrl_flow_o), 32'h1);
        drive_a(2'b00, 16'h0, 16'h0, 2'b00, 2'b11);
        chk("br_add_ready", 32'(bus_a.dec_ready_o), 32'h3);
        tick();
        drive_a(2'b00, 16'h0, 16'h0, 2'b00, 2'b00);
        chk("br_pop_slot0", 32'(bus_a.issue_data_o[15:0]), 32'h0AD0);
        chk("br_pop_valid", 32'(bus_a.issue_valid_o), 32'h1);
        drive_a(2'b00, 16'h0, 16'h0, 2'b00, 2'b01);
        tick();

        drive_a(2'b11, 16'h0AD1, 16'h0B01, 2'b10, 2'b00);
        tick();
        drive_a(2'b00, 16'h0, 16'h0, 2'b00, 2'b00);
        chk("add_br_valid", 32'(bus_a.issue_valid_o), 32'h1);
        chk("add_br_slot0", 32'(bus_a.issue_data_o[15:0]), 32'h0AD1);
        drive_a(2'b00, 16'h0, 16'h0, 2'b00, 2'b11);
        tick();
        drive_a(2'b00, 16'h0, 16'h0, 2'b00, 2'b00);
        chk("add_br_pop_slot0", 32'(bus_a.issue_data_o[15:0]), 32'h0B01);
        chk("add_br_pop_valid", 32'(bus_a.issue_valid_o), 32'h1);
        chk("add_br_pop_cf", 32'(bus_a.issue_ctrl_flow_o[0]), 32'h1);
        drive_a(2'b00, 16'h0, 16'h0, 2'b00, 2'b01);
        tick();

        drive_a(2'b11, 16'h0011, 16'h0022, 2'b00, 2'b00);
        tick();
        drive_a(2'b01, 16'h0033, 16'h0, 2'b00, 2'b00);
        tick();
        drive_a(2'b11, 16'h00AA, 16'h00BB, 2'b00, 2'b00);
        flush_a = 1'b1;
        chk("flush_ready_in", 32'(bus_a.dec_ready_o), 32'h1);
        tick();
        flush_a = 1'b0;
        drive_a(2'b00, 16'h0, 16'h0, 2'b00, 2'b00);
        chk("flush_valid", 32'(bus_a.issue_valid_o), 32'h0);
        chk("flush_ready", 32'(bus_a.dec_ready_o), 32'h3);
        tick();
        chk("flush_still_empty", 32'(bus_a.issue_valid_o), 32'h0);
        drive_a(2'b11, 16'h0055, 16'h0066, 2'b00, 2'b00);
        tick();
        drive_a(2'b00, 16'h0, 16'h0, 2'b00, 2'b00);
        chk("post_flush_slot0", 32'(bus_a.issue_data_o[15:0]), 32'h0055);
        chk("post_flush_slot1", 32'(bus_a.issue_data_o[31:16]), 32'h0066);

        seq = 16'h0100;
        for (int c = 0; c < 16; c++) begin
            nv  = (c < 2) ? 2 : int'($urandom_range(0, 2));
            ack = (c < 2) ? 2'b00 : 2'($urandom_range(0, 3));
            bus_b.dec_valid_i = (nv == 0) ? 2'b00 : (nv == 1) ? 2'b01 : 2'b11;
            bus_b.dec_data_i  = {seq + 16'h1, seq};
            bus_b.issue_ack_i = ack;
            #1;
            pops = 0;
            if (q.size() > 0 && ack[0]) begin
                pops = 1;
                if (q.size() > 1 && ack[1]) pops = 2;
            end
            free = 3 - q.size() + pops;
            chk($sformatf("wrap%0d_valid", c), 32'(bus_b.issue_valid_o),
                {30'h0, q.size() > 1, q.size() > 0});
            chk($sformatf("wrap%0d_ready", c), 32'(bus_b.dec_ready_o),
                {30'h0, free > 1, free > 0});
            if (q.size() > 0)
                chk($sformatf("wrap%0d_slot0", c),
                    32'(bus_b.issue_data_o[15:0]), 32'(q[0]));
            if (q.size() > 1)
                chk($sformatf("wrap%0d_slot1", c),
                    32'(bus_b.issue_data_o[31:16]), 32'(q[1]));
            for (int p = 0; p < pops; p++) void'(q.pop_front());
            pushes = (nv < free) ? nv : free;
            for (int k = 0; k < pushes; k++) q.push_back(seq + 16'(k));
            seq = seq + 16'(pushes);
            tick();
        end
        bus_b.dec_valid_i = '0;
        bus_b.issue_ack_i = '0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end
endmodule
